// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port scheduler.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam int REQ_ALU  = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_HOST = 2;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first active request at or after rr_ptr wins.
module rr_arbiter #(
    parameter int  N_REQ = 3,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    // cand[k] is the requester examined k-th, i.e. (rr_ptr + k) mod N_REQ
    logic [IDX_W-1:0] cand [N_REQ];
    logic             found;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
        assign cand[gi] = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                     : sum[IDX_W-1:0];
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (enable) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req[cand[k]]) begin
                    found            = 1'b1;
                    grant_idx        = cand[k];
                    grant[cand[k]]   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_wr_sched.sv
// Shares the register file's single write port among requesters and runs a
// whole-file clear sequence; also counts cycles in which a request was kept waiting.
module reg_wr_sched #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         ack,
    input  logic                     clr_start,
    output logic                     busy,
    output logic                     clr_done,
    output logic                     LD_REG,
    output logic [ADDR_W-1:0]        DR_addr,
    output logic [DATA_W-1:0]        In,
    output logic [CNT_W-1:0]         stall_cnt
);
    import regfile_pkg::*;

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int N_REGS = 2 ** ADDR_W;

    sched_state_t      state_reg, state_next;
    logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
    logic              ld_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic              done_next;
    logic [CNT_W-1:0]  stall_next;

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              arb_en;

    // Reset_n gates the grant so ack is quiet for the whole reset interval
    assign arb_en = Reset_n && (state_reg == ARB) && !clr_start;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr_reg),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign ack  = grant;
    assign busy = (state_reg == CLEAR);

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        clr_cnt_next = clr_cnt_reg;
        ld_next      = 1'b0;
        addr_next    = DR_addr;
        data_next    = In;
        done_next    = 1'b0;
        case (state_reg)
            ARB: begin
                if (clr_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end else if (|grant) begin
                    ld_next     = 1'b1;
                    addr_next   = req_addr[grant_idx*ADDR_W +: ADDR_W];
                    data_next   = req_data[grant_idx*DATA_W +: DATA_W];
                    rr_ptr_next = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                end
            end
            CLEAR: begin
                ld_next      = 1'b1;
                addr_next    = clr_cnt_reg;
                data_next    = '0;
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == ADDR_W'(N_REGS-1)) begin
                    state_next   = ARB;
                    clr_cnt_next = '0;
                    done_next    = 1'b1;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_comb begin
        stall_next = stall_cnt;
        if (|(req & ~ack) && !(&stall_cnt))
            stall_next = stall_cnt + 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg   <= ARB;
            rr_ptr_reg  <= '0;
            clr_cnt_reg <= '0;
            LD_REG      <= 1'b0;
            DR_addr     <= '0;
            In          <= '0;
            clr_done    <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            clr_cnt_reg <= clr_cnt_next;
            LD_REG      <= ld_next;
            DR_addr     <= addr_next;
            In          <= data_next;
            clr_done    <= done_next;
            stall_cnt   <= stall_next;
        end
    end

endmodule

// File: tb/tb_reg_wr_sched.sv
// Randomized and directed checks of reg_wr_sched against a behavioural model
// that owns its own copy of the register file.
module tb_reg_wr_sched;
    import regfile_pkg::*;

    localparam int N = 3;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*3-1:0]  req_addr = '0;
    logic [N*16-1:0] req_data = '0;
    logic            clr_start = 1'b0;

    logic [N-1:0] ack, ack4;
    logic         busy, busy4, clr_done, done4, LD_REG, ld4;
    logic [2:0]   DR_addr, addr4;
    logic [15:0]  In, data4;
    logic [15:0]  stall_cnt;
    logic [3:0]   stall4;

    always #5 Clk = ~Clk;

    reg_wr_sched #(.N_REQ(N), .DATA_W(16), .ADDR_W(3), .CNT_W(16)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
        .LD_REG(LD_REG), .DR_addr(DR_addr), .In(In), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, to exercise saturation
    reg_wr_sched #(.N_REQ(N), .DATA_W(16), .ADDR_W(3), .CNT_W(4)) u_dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack4), .clr_start(clr_start), .busy(busy4), .clr_done(done4),
        .LD_REG(ld4), .DR_addr(addr4), .In(data4), .stall_cnt(stall4)
    );

    // Register file fed by the DUT's write port
    logic [15:0] rf [8] = '{default: 16'h0};
    always @(posedge Clk) if (LD_REG) rf[DR_addr] <= In;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr, m_cidx, m_stall;
    bit          m_clear, m_ld, m_done;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    logic [15:0] m_rf [8] = '{default: 16'h0};

    logic [2:0]  a_addr [N];
    logic [15:0] a_data [N];
    logic [N-1:0] last_ack;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cidx = 0; m_stall = 0;
        m_clear = 0; m_ld = 0; m_done = 0;
        m_addr = '0; m_data = '0;
    endtask

    // Winner is the requester with the smallest circular distance from the pointer
    function automatic logic [N-1:0] model_ack(input logic [N-1:0] r, input logic cs);
        int best = -1;
        int bestd = N;
        if (m_clear || cs) return '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                int d = (i - m_ptr + N) % N;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        return (best < 0) ? '0 : N'(1 << best);
    endfunction

    task automatic model_edge(input logic [N-1:0] r, input logic cs, input logic [N-1:0] ea);
        int g = 0;
        if (m_ld) m_rf[m_addr] = m_data;
        if (|(r & ~ea)) m_stall++;
        m_done = 0;
        if (m_clear) begin
            m_ld = 1; m_addr = 3'(m_cidx); m_data = '0;
            if (m_cidx == NUM_REGS-1) begin m_clear = 0; m_done = 1; end
            m_cidx++;
        end else if (cs) begin
            m_clear = 1; m_cidx = 0; m_ld = 0;
        end else if (ea != '0) begin
            for (int i = 0; i < N; i++) if (ea[i]) g = i;
            m_ld = 1; m_addr = a_addr[g]; m_data = a_data[g];
            m_ptr = (g + 1) % N;
        end else begin
            m_ld = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic [N-1:0] r, input logic cs);
        logic [N-1:0] ea;
        @(negedge Clk);
        req = r;
        clr_start = cs;
        for (int i = 0; i < N; i++) begin
            req_addr[i*3 +: 3]   = a_addr[i];
            req_data[i*16 +: 16] = a_data[i];
        end
        #1;
        ea = model_ack(r, cs);
        last_ack = ack;
        chk("ack", ack, ea);
        chk("ack4", ack4, ea);
        chk("busy", busy, m_clear);
        @(posedge Clk);
        model_edge(r, cs, ea);
        #1;
        chk("ld", LD_REG, m_ld);
        chk("dr_addr", DR_addr, m_addr);
        chk("in", In, m_data);
        chk("clr_done", clr_done, m_done);
        chk("stall", stall_cnt, sat(m_stall, 65535));
        chk("stall4", stall4, sat(m_stall, 15));
        chk("dut4_out", {ld4, addr4, data4, done4, busy4}, {m_ld, m_addr, m_data, m_done, m_clear});
        if (LD_REG)
            $display("write addr=%0d data=%04h done=%0b stall=%0d", DR_addr, In, clr_done, stall_cnt);
    endtask

    // Asynchronous reset asserted between clock edges, with all requests pending
    task automatic apply_reset();
        @(negedge Clk);
        req = '1;
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_out", {LD_REG, DR_addr, In, clr_done, busy}, 0);
        chk("rst_stall", stall_cnt, 0);
        model_reset();
        @(negedge Clk);
        req = '0;
        Reset_n = 1'b1;
    endtask

    task automatic preload();
        for (int i = 0; i < NUM_REGS; i++) begin
            a_addr[REQ_HOST] = 3'(i);
            a_data[REQ_HOST] = 16'((i + 1) * 16'h1111);
            cycle(3'b100, 1'b0);
        end
        cycle(3'b000, 1'b0);
    endtask

    task automatic compare_rf(input string tag);
        for (int i = 0; i < NUM_REGS; i++) chk(tag, rf[i], m_rf[i]);
    endtask

    logic [N-1:0] seq [6];
    int zeros;

    initial begin
        for (int i = 0; i < N; i++) begin a_addr[i] = '0; a_data[i] = '0; end
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
        seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
        model_reset();

        // Reset state
        repeat (2) @(negedge Clk);
        req = '1;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_out", {LD_REG, DR_addr, In, clr_done, busy}, 0);
        chk("rst_stall", stall_cnt, 0);
        req = '0;
        Reset_n = 1'b1;

        // Single ALU write
        a_addr[REQ_ALU] = 3'd3; a_data[REQ_ALU] = 16'hBEEF;
        cycle(3'b001, 1'b0);
        chk("t1_ack", last_ack, 3'b001);
        chk("t1_addr", DR_addr, 3);
        chk("t1_data", In, 16'hBEEF);
        cycle(3'b000, 1'b0);
        chk("t1_rf3", rf[3], 16'hBEEF);

        // Full contention rotates 0,1,2
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) begin
                a_addr[i] = 3'((k + i) % 8);
                a_data[i] = 16'(16'hA000 + k * 16 + i);
            end
            cycle(3'b111, 1'b0);
            chk("rr_seq", last_ack, seq[k]);
        end
        chk("t2_stall", stall_cnt, 6);
        cycle(3'b000, 1'b0);

        // Preload then clear the whole file
        preload();
        compare_rf("rf_preload");
        cycle(3'b000, 1'b1);
        for (int k = 0; k < NUM_REGS; k++) cycle(3'b000, 1'b0);
        chk("t3_done", clr_done, 1);
        chk("t3_addr7", DR_addr, 7);
        cycle(3'b000, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) chk("t3_rf_zero", rf[i], 0);

        // clr_start together with a memory request
        apply_reset();
        a_addr[REQ_MEM] = 3'd5; a_data[REQ_MEM] = 16'h5A5A;
        zeros = 0;
        for (int k = 0; k < 9; k++) begin
            cycle(3'b010, (k == 0) ? 1'b1 : 1'b0);
            if (last_ack == '0) zeros++;
        end
        chk("t4_zero_acks", zeros, 9);
        cycle(3'b010, 1'b0);
        chk("t4_grant", last_ack, 3'b010);
        chk("t4_stall", stall_cnt, 9);

        // Reset in the middle of a clear
        preload();
        cycle(3'b000, 1'b1);
        for (int k = 0; k < 5; k++) cycle(3'b000, 1'b0);
        apply_reset();
        for (int i = 0; i < 4; i++) chk("t5_cleared", rf[i], 0);
        for (int i = 4; i < NUM_REGS; i++) chk("t5_kept", rf[i], 32'((i + 1) * 16'h1111));
        cycle(3'b111, 1'b0);
        chk("t5_ptr0", last_ack, 3'b001);

        // Random traffic, including clr_start during CLEAR and withdrawn requests
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                a_addr[i] = 3'($urandom_range(0, 7));
                a_data[i] = 16'($urandom);
            end
            cycle(N'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
        end
        for (int k = 0; k < 10; k++) cycle(3'b000, 1'b0);
        compare_rf("rf_random");
        chk("sat4", stall4, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_wr_sched.md
Name: reg_wr_sched

Overview:
- Write-port scheduler for the 8 x 16-bit register file.
- Shares the file's single write port (LD_REG / DR_addr / In) among N_REQ requesters using round-robin arbitration with a req/ack handshake.
- Contains a clear sequencer that zeroes all registers in NUM_REGS consecutive cycles on command.
- Tracks contention with a saturating stall counter for debug.

Parameters:
- N_REQ, 3, number of write requesters (index 0 = ALU writeback, 1 = memory load, 2 = host/debug).
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W = 8.
- CNT_W, 16, width of the stall counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester write request; held until acked.
- req_addr  in  N_REQ*ADDR_W  packed destination addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  packed write data; same packing.
- ack  out  N_REQ  one-hot grant, combinational; transfer occurs on the edge where req[i] & ack[i].
- clr_start  in  1  single-cycle command to zero all registers.
- busy  out  1  high while the clear sequence runs.
- clr_done  out  1  single-cycle pulse coincident with the final clear write.
- LD_REG  out  1  register-file write enable (registered).
- DR_addr  out  ADDR_W  register-file write address (registered).
- In  out  DATA_W  register-file write data (registered).
- stall_cnt  out  CNT_W  saturating count of cycles in which at least one request was left waiting.

Behaviour:
- Reset: Reset_n low forces asynchronously:
  - state = ARB, rr_ptr = 0, clr_cnt = 0
  - LD_REG = 0, DR_addr = 0, In = 0
  - busy = 0, clr_done = 0, stall_cnt = 0
  - ack = 0 while Reset_n is low
- FSM states: ARB, CLEAR.
- ARB, grant rule:
  - If clr_start = 1: no ack this cycle, next state CLEAR, clr_cnt <= 0; requests keep waiting.
  - Otherwise grant the first i with req[i] = 1, searching rr_ptr, rr_ptr+1, ... mod N_REQ. Only that ack[i] = 1.
- ARB, on the edge after a grant to i:
  - LD_REG <= 1, DR_addr <= req_addr[i], In <= req_data[i]
  - rr_ptr <= (i+1) mod N_REQ
- ARB, no request and no clr_start: LD_REG <= 0; DR_addr and In hold their values; rr_ptr holds.
- Latency:
  - Grant at cycle t, LD_REG high in t+1, register written at the end of t+1.
  - Data readable on SR outputs in t+2.
  - Maximum throughput is one write per cycle.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,0,... and no requester waits more than N_REQ-1 grants.
- CLEAR, each cycle:
  - LD_REG <= 1, DR_addr <= clr_cnt, In <= 0, clr_cnt <= clr_cnt+1
  - busy = 1 combinationally in CLEAR; ack = 0
- CLEAR exit:
  - On the edge where clr_cnt = NUM_REGS-1: next state ARB, clr_cnt <= 0, clr_done <= 1 for one cycle, aligned with LD_REG/DR_addr = 7.
  - The first arbitration grant is possible in the cycle after exit.
  - Total: NUM_REGS write cycles.
- clr_start while in CLEAR is ignored; the sequence is not restarted.
- Consecutive writes to the same address are allowed; the last write wins.
- stall_cnt increments by 1 in any cycle where popcount(req & ~ack) >= 1, including every cycle of CLEAR with a pending req and the clr_start cycle. It saturates at all-ones.
- Reset asserted mid-CLEAR aborts the sequence. Registers not yet written keep their contents in the file; no clr_done.
- req dropped before ack is legal: the request is withdrawn and no write occurs.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W, ADDR_W, NUM_REGS constants
  - sched_state_t enum {ARB, CLEAR}
  - requester index constants REQ_ALU = 0, REQ_MEM = 1, REQ_HOST = 2
- Sub-module rr_arbiter: N_REQ-wide combinational round-robin priority pick. Inputs req, rr_ptr, enable; outputs one-hot grant and grant index.
- FSM, output registers, clear counter and stall counter live in reg_wr_sched.

Test Plan:
- Reset then single request: req = 001, req_addr[0] = 3, req_data[0] = 16'hBEEF → ack = 001 the same cycle; next cycle LD_REG = 1, DR_addr = 3, In = BEEF; register 3 reads BEEF two cycles after grant.
- All three requesters held for 6 cycles, each with distinct data → ack sequence 001,010,100,001,010,100; writes in that order; stall_cnt = 6.
- Clear: preload registers 0..7 = 16'h1111..16'h8888, pulse clr_start → busy for 8 cycles, DR_addr 0..7 with In = 0; clr_done high with DR_addr = 7; all registers read 0.
- clr_start coincident with req = 010 → ack = 000 for 9 cycles (start + 8 clear); request 1 is granted in the cycle after clr_done; stall_cnt = 9.
- Reset_n pulled low asynchronously mid-clear, after DR_addr = 3 is written → outputs zero immediately; registers 4..7 retain their preload; rr_ptr = 0 afterwards.
- stall_cnt preset near saturation via a long contention run, e.g. a run with CNT_W = 4 → counter holds at 4'hF with no wrap.
